// File: rtl/i2c_slave_block_if.sv
// Byte-level and pad-level signal bundle between the I2C target engine and its user.
interface i2c_slave_block_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_o;
    logic       rx_ack_i;
    logic [7:0] tx_data_i;
    logic       tx_req_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       addressed_o;
    logic       rw_o;
    logic       gen_call_o;
    logic       master_nack_o;
    logic       busy_o;

    modport slave (
        input  scl_i, sda_i, rx_ack_i, tx_data_i,
        output sda_o, tx_req_o, rx_data_o, rx_valid_o, addressed_o,
               rw_o, gen_call_o, master_nack_o, busy_o
    );

    modport master (
        output scl_i, sda_i, rx_ack_i, tx_data_i,
        input  sda_o, tx_req_o, rx_data_o, rx_valid_o, addressed_o,
               rw_o, gen_call_o, master_nack_o, busy_o
    );
endinterface

// File: rtl/i2c_slave_block.sv
// I2C target protocol engine: START/STOP detection, 7-bit address match, byte rx/tx.
// Optional general-call (address 8'h00) support when I2C_SLAVE_GENERAL_CALL_EN is defined.
module i2c_slave_block #(
    parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
    input  logic             i2c_core_clock_i,
    input  logic             reset_bit_i,
    i2c_slave_block_if.slave bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned SYNC_W = 3;
    localparam logic [CNT_W-1:0] CNT_TOP = '1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK
    } state_t;

    state_t              state;
    logic [SYNC_W-1:0]   scl_sync;
    logic [SYNC_W-1:0]   sda_sync;
    logic [CNT_W-1:0]    bit_cnt;
    logic [BYTE_W-1:0]   shift_q;
    logic                byte_done;
    logic                ack_bit;
    logic                sda_q;
    logic [BYTE_W-1:0]   rx_data_q;
    logic                rx_valid_q;
    logic                addressed_q;
    logic                rw_q;
    logic                nack_q;
    logic                busy_q;

    logic                scl_rise;
    logic                scl_fall;
    logic                start_det;
    logic                stop_det;
    logic                addr_match;
    logic                gc_match;
    logic [BYTE_W-1:0]   rx_byte;

    // Stage 2 is the synchronized level, stage 3 the previous sample for edges.
    assign scl_rise  =  scl_sync[1] & ~scl_sync[2];
    assign scl_fall  = ~scl_sync[1] &  scl_sync[2];
    assign start_det =  scl_sync[1] &  scl_sync[2] & ~sda_sync[1] &  sda_sync[2];
    assign stop_det  =  scl_sync[1] &  scl_sync[2] &  sda_sync[1] & ~sda_sync[2];

    assign rx_byte    = {shift_q[BYTE_W-2:0], sda_sync[1]};
    assign addr_match = (shift_q[BYTE_W-1:1] == SLAVE_ADDR);

    always_ff @(posedge i2c_core_clock_i) begin
        if (reset_bit_i) begin
            scl_sync    <= '1;
            sda_sync    <= '1;
            state       <= IDLE;
            bit_cnt     <= CNT_TOP;
            shift_q     <= '0;
            byte_done   <= 1'b0;
            ack_bit     <= 1'b1;
            sda_q       <= 1'b1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            addressed_q <= 1'b0;
            rw_q        <= 1'b0;
            nack_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            scl_sync   <= {scl_sync[SYNC_W-2:0], bus.scl_i};
            sda_sync   <= {sda_sync[SYNC_W-2:0], bus.sda_i};
            rx_valid_q <= 1'b0;
            nack_q     <= 1'b0;

            if (start_det) begin
                state       <= ADDR;
                bit_cnt     <= CNT_TOP;
                byte_done   <= 1'b0;
                addressed_q <= 1'b0;
                busy_q      <= 1'b1;
                sda_q       <= 1'b1;
            end else if (stop_det) begin
                state       <= IDLE;
                byte_done   <= 1'b0;
                addressed_q <= 1'b0;
                busy_q      <= 1'b0;
                sda_q       <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        sda_q <= 1'b1;
                    end
                    ADDR: begin
                        if (scl_rise) begin
                            shift_q <= rx_byte;
                            if (bit_cnt == '0) byte_done <= 1'b1;
                            else               bit_cnt   <= bit_cnt - CNT_W'(1);
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            if (addr_match || gc_match) begin
                                state       <= ADDR_ACK;
                                sda_q       <= 1'b0;
                                rw_q        <= shift_q[0];
                                addressed_q <= 1'b1;
                            end else begin
                                state <= IDLE;
                                sda_q <= 1'b1;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= CNT_TOP;
                            if (rw_q) begin
                                state   <= RD_DATA;
                                shift_q <= bus.tx_data_i;
                                sda_q   <= bus.tx_data_i[BYTE_W-1];
                            end else begin
                                state <= WR_DATA;
                                sda_q <= 1'b1;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shift_q <= rx_byte;
                            if (bit_cnt == '0) begin
                                byte_done  <= 1'b1;
                                rx_data_q  <= rx_byte;
                                rx_valid_q <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt - CNT_W'(1);
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            state     <= WR_ACK;
                            sda_q     <= bus.rx_ack_i;
                        end
                    end
                    WR_ACK: begin
                        // NACK takes the same path; the master is expected to STOP.
                        if (scl_fall) begin
                            state   <= WR_DATA;
                            bit_cnt <= CNT_TOP;
                            sda_q   <= 1'b1;
                        end
                    end
                    RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == '0) begin
                                state <= RD_ACK;
                                sda_q <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt - CNT_W'(1);
                                shift_q <= {shift_q[BYTE_W-2:0], 1'b0};
                                sda_q   <= shift_q[BYTE_W-2];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            ack_bit <= sda_sync[1];
                        end else if (scl_fall) begin
                            if (!ack_bit) begin
                                state   <= RD_DATA;
                                bit_cnt <= CNT_TOP;
                                shift_q <= bus.tx_data_i;
                                sda_q   <= bus.tx_data_i[BYTE_W-1];
                            end else begin
                                nack_q <= 1'b1;
                                state  <= IDLE;
                                sda_q  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        sda_q <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    logic gen_call_q;

    // Only the write form of the general call is answered.
    assign gc_match = (shift_q == BYTE_W'(0));

    always_ff @(posedge i2c_core_clock_i) begin
        if (reset_bit_i) begin
            gen_call_q <= 1'b0;
        end else if (start_det || stop_det) begin
            gen_call_q <= 1'b0;
        end else if (state == ADDR && scl_fall && byte_done && gc_match && !addr_match) begin
            gen_call_q <= 1'b1;
        end
    end

    assign bus.gen_call_o = gen_call_q;
`else
    assign gc_match       = 1'b0;
    assign bus.gen_call_o = 1'b0;
`endif

    // Decoded from flops so tx_data_i is sampled in the same cycle as the fall detection.
    assign bus.tx_req_o = scl_fall &&
                          ((state == ADDR_ACK && rw_q) || (state == RD_ACK && !ack_bit));

    assign bus.sda_o         = sda_q;
    assign bus.rx_data_o     = rx_data_q;
    assign bus.rx_valid_o    = rx_valid_q;
    assign bus.addressed_o   = addressed_q;
    assign bus.rw_o          = rw_q;
    assign bus.master_nack_o = nack_q;
    assign bus.busy_o        = busy_q;
endmodule
